// File: rtl/multichan_delayer_pkg.sv
// Shared mode encoding for the multichannel qualification/delay stage.
package multichan_delayer_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ARM    = 2'd0;
  localparam mode_t MODE_FILT   = 2'd1;
  localparam mode_t MODE_PULSE  = 2'd2;
  localparam mode_t MODE_BYPASS = 2'd3;
endpackage

// File: rtl/multichan_delayer_chan.sv
// One channel: hold-off / glitch-filter / delayed-pulse counter and output mux.
module delayer_chan
  import multichan_delayer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] dly_i,
  input  mode_t            mode_i,
  input  logic             sig_i,
  output logic             sig_o,
  output logic             armed_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             pulse_q, pulse_d;
  logic             in_q;
  logic             rise, cnt_full, cnt_zero;

  assign rise     = sig_i & ~in_q;
  assign cnt_full = (cnt_q == dly_i);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    pulse_d  = pulse_q;
    if (clr_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
      pulse_d  = 1'b0;
    end else begin
      case (mode_i)
        MODE_ARM, MODE_FILT: begin
          active_d = 1'b0;
          pulse_d  = 1'b0;
          if (en_i) begin
            if (sig_i && (cnt_q < dly_i)) cnt_d = cnt_q + CNT_W'(1);
            else if (!sig_i && (mode_i == MODE_FILT)) cnt_d = '0;
          end
        end
        MODE_PULSE: begin
          pulse_d = 1'b0;
          if (en_i) begin
            // a rise on the firing edge still emits the old pulse and reloads
            pulse_d = active_q & cnt_zero;
            if (rise) begin
              cnt_d    = dly_i;
              active_d = 1'b1;
            end else if (active_q) begin
              if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
              else active_d = 1'b0;
            end
          end
        end
        default: begin
          cnt_d    = '0;
          active_d = 1'b0;
          pulse_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      in_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
      in_q     <= sig_i;
    end
  end

  always_comb begin
    sig_o   = 1'b0;
    armed_o = 1'b0;
    case (mode_i)
      MODE_ARM, MODE_FILT: begin
        sig_o   = sig_i & cnt_full;
        armed_o = cnt_full;
      end
      MODE_PULSE: begin
        sig_o   = pulse_q;
        armed_o = active_q;
      end
      default: begin
        sig_o   = sig_i;
        armed_o = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/multichan_delayer.sv
// Per-channel programmable qualification/delay stage for the capture path.
// Holds per-channel delay/mode config and instantiates one delayer_chan per channel.
module multichan_delayer
  import multichan_delayer_pkg::*;
#(
  parameter  int CHANNELS      = 4,
  parameter  int CNT_W         = 8,
  parameter  int DEFAULT_DELAY = 5,
  parameter  int DEFAULT_MODE  = 0,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                rdclk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_delay,
  input  logic [1:0]          cfg_mode,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] armed
);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  logic cfg_ok;
  assign cfg_ok = cfg_wr && ({1'b0, cfg_ch} < CH_LIM);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] dly_q;
    mode_t            mode_q;
    logic             hit;

    assign hit = cfg_ok && (cfg_ch == CH_W'(g));

    always_ff @(posedge rdclk or posedge reset) begin
      if (reset) begin
        dly_q  <= CNT_W'(DEFAULT_DELAY);
        mode_q <= mode_t'(DEFAULT_MODE);
      end else if (hit) begin
        dly_q  <= cfg_delay;
        mode_q <= mode_t'(cfg_mode);
      end
    end

    // a config write clears the channel's counting state on the same edge
    delayer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk_i   (rdclk),
      .rst_i   (reset),
      .en_i    (en),
      .clr_i   (clr | hit),
      .dly_i   (dly_q),
      .mode_i  (mode_q),
      .sig_i   (sig_in[g]),
      .sig_o   (sig_out[g]),
      .armed_o (armed[g])
    );
  end
endmodule

// File: tb/tb_multichan_delayer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_multichan_delayer;
  localparam int CH      = 5;
  localparam int CW      = 8;
  localparam int CHW     = 3;
  localparam int DEF_DLY = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           en, clr, cfg_wr;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_delay;
  logic [1:0]     cfg_mode;
  logic [CH-1:0]  sig_in, sig_out, armed;

  int n_tests = 0;
  int n_fail  = 0;

  // model: ARM/FILT keep unsaturated high counts; PULSE keeps an absolute firing time
  int m_dly[CH], m_mode[CH], m_cnt[CH], m_tgt[CH];
  bit m_pend[CH], m_pout[CH], m_inp[CH];
  int en_idx;

  logic [CH-1:0] last_so, last_ar;

  always #5 clk = ~clk;

  multichan_delayer #(
    .CHANNELS(CH), .CNT_W(CW), .DEFAULT_DELAY(DEF_DLY), .DEFAULT_MODE(0)
  ) dut (
    .rdclk(clk), .reset(rst), .en(en), .clr(clr), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_mode(cfg_mode),
    .sig_in(sig_in), .sig_out(sig_out), .armed(armed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [CH-1:0] exp_out(input logic [CH-1:0] s);
    logic [CH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      case (m_mode[i])
        0, 1:    r[i] = s[i] && (m_cnt[i] >= m_dly[i]);
        2:       r[i] = m_pout[i];
        default: r[i] = s[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_armed();
    logic [CH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      case (m_mode[i])
        0, 1:    r[i] = (m_cnt[i] >= m_dly[i]);
        2:       r[i] = m_pend[i];
        default: r[i] = 1'b1;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_dly[i] = DEF_DLY; m_mode[i] = 0; m_cnt[i] = 0; m_tgt[i] = 0;
      m_pend[i] = 0; m_pout[i] = 0; m_inp[i] = 0;
    end
    en_idx = 0;
  endtask

  task automatic model_step(input logic e, input logic c, input logic w,
                            input int ch, input int d, input int m,
                            input logic [CH-1:0] s);
    bit hit;
    for (int i = 0; i < CH; i++) begin
      hit = c || (w && ch == i);
      if (hit) begin
        m_cnt[i] = 0; m_pend[i] = 0; m_pout[i] = 0;
      end else begin
        case (m_mode[i])
          0: begin
            if (e && s[i]) m_cnt[i]++;
            m_pout[i] = 0;
          end
          1: begin
            if (e) m_cnt[i] = s[i] ? m_cnt[i] + 1 : 0;
            m_pout[i] = 0;
          end
          2: begin
            if (!e) m_pout[i] = 0;
            else begin
              m_pout[i] = m_pend[i] && (m_tgt[i] == en_idx);
              if (m_pout[i]) m_pend[i] = 0;
              if (s[i] && !m_inp[i]) begin
                m_pend[i] = 1;
                m_tgt[i]  = en_idx + m_dly[i] + 1;
              end
            end
          end
          default: begin
            m_cnt[i] = 0; m_pout[i] = 0; m_pend[i] = 0;
          end
        endcase
      end
      m_inp[i] = s[i];
      if (w && ch == i) begin
        m_dly[i] = d; m_mode[i] = m;
      end
    end
    if (e) en_idx++;
  endtask

  task automatic cycle(input logic e, input logic c, input logic w,
                       input int ch, input int d, input int m,
                       input logic [CH-1:0] s);
    @(negedge clk);
    en = e; clr = c; cfg_wr = w; cfg_ch = CHW'(ch);
    cfg_delay = CW'(d); cfg_mode = 2'(m); sig_in = s;
    #1;
    last_so = sig_out;
    last_ar = armed;
    chk("sig_out", 32'(last_so), 32'(exp_out(s)));
    chk("armed", 32'(last_ar), 32'(exp_armed()));
    model_step(e, c, w, ch, d, m, s);
  endtask

  task automatic idle_inputs();
    en = 1'b0; clr = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
    cfg_delay = '0; cfg_mode = '0; sig_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_sig_out", 32'(sig_out), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [CH-1:0] s, lvl;
    int first0, first1, first2, cnt1, cnt2, early;
    logic e, c, w;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("por_sig_out", 32'(sig_out), 32'd0);
    chk("por_armed", 32'(armed), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: ARM dly=5, ch0 held high
    first0 = -1;
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 5'b00001);
      if (last_so[0] && first0 < 0) first0 = k;
      if (k == 5) chk("t1_armed_c5", 32'(last_ar[0]), 32'd1);
    end
    chk("t1_first_out", 32'(first0), 32'd5);

    // 2: FILT dly=3 on ch1, runs of 2 and 6
    cycle(1, 0, 1, 1, 3, 1, '0);
    cnt1 = 0; early = 0; first1 = -1;
    for (int k = 0; k < 10; k++) begin
      s = ((k < 2) || (k >= 3 && k < 9)) ? 5'b00010 : 5'b00000;
      cycle(1, 0, 0, 0, 0, 0, s);
      if (last_so[1]) begin
        cnt1++;
        if (k < 3) early++;
        if (first1 < 0) first1 = k;
      end
    end
    chk("t2_first_run", 32'(early), 32'd0);
    chk("t2_high_cnt", 32'(cnt1), 32'd3);
    chk("t2_first_out", 32'(first1), 32'd6);

    // 3: PULSE dly=4 on ch2, single rise then retrigger
    cycle(1, 0, 1, 2, 4, 2, '0);
    cnt2 = 0; first2 = -1;
    for (int k = 0; k < 12; k++) begin
      cycle(1, 0, 0, 0, 0, 0, (k == 0) ? 5'b00100 : 5'b00000);
      if (last_so[2]) begin cnt2++; if (first2 < 0) first2 = k; end
    end
    chk("t3_pulse_cnt", 32'(cnt2), 32'd1);
    chk("t3_pulse_pos", 32'(first2), 32'd6);
    cnt2 = 0; first2 = -1;
    for (int k = 0; k < 14; k++) begin
      cycle(1, 0, 0, 0, 0, 0, (k == 0 || k == 2) ? 5'b00100 : 5'b00000);
      if (last_so[2]) begin cnt2++; if (first2 < 0) first2 = k; end
    end
    chk("t3_retrig_cnt", 32'(cnt2), 32'd1);
    chk("t3_retrig_pos", 32'(first2), 32'd8);

    // 4: en low for three cycles mid-count
    cycle(1, 1, 0, 0, 0, 0, '0);
    first0 = -1; cnt2 = 0; first2 = -1;
    for (int k = 0; k < 12; k++) begin
      e = !(k >= 2 && k <= 4);
      cycle(e, 0, 0, 0, 0, 0, (k == 0) ? 5'b00101 : 5'b00001);
      if (last_so[0] && first0 < 0) first0 = k;
      if (last_so[2]) begin cnt2++; if (first2 < 0) first2 = k; end
    end
    chk("t4_arm_pos", 32'(first0), 32'd8);
    chk("t4_pulse_cnt", 32'(cnt2), 32'd1);
    chk("t4_pulse_pos", 32'(first2), 32'd9);

    // 5: reconfigure ch2 while ch1 counts; out-of-range write
    cycle(1, 0, 1, 1, 4, 0, '0);
    first1 = -1;
    for (int k = 0; k < 8; k++) begin
      s = 5'b00010;
      s[2] = 1'($urandom_range(1));
      w = (k == 2 || k == 3);
      cycle(1, 0, w, (k == 2) ? 2 : 7, 0, (k == 2) ? 1 : 3, s);
      if (last_so[1] && first1 < 0) first1 = k;
      if (k >= 3) chk("t5_ch2_pass", 32'(last_so[2]), 32'(s[2]));
    end
    chk("t5_ch1_pos", 32'(first1), 32'd4);

    // 6: clr during PULSE countdown, then async reset mid-countdown
    cycle(1, 0, 1, 2, 4, 2, '0);
    cnt2 = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1, (k == 2), 0, 0, 0, 0, (k == 0) ? 5'b00100 : 5'b00000);
      if (last_so[2]) cnt2++;
    end
    chk("t6_clr_no_pulse", 32'(cnt2), 32'd0);
    cycle(1, 0, 0, 0, 0, 0, 5'b00100);
    cycle(1, 0, 0, 0, 0, 0, 5'b00000);
    do_reset();
    cnt2 = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 0, 0, 0, 0, '0);
      if (last_so[2]) cnt2++;
    end
    chk("t6_rst_no_pulse", 32'(cnt2), 32'd0);
    first0 = -1;
    for (int k = 0; k < 7; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 5'b00001);
      if (last_so[0] && first0 < 0) first0 = k;
    end
    chk("t6_default_dly", 32'(first0), 32'd5);

    // randomized traffic against the model
    lvl = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(3) == 0) lvl[i] = ~lvl[i];
      e = ($urandom_range(7) != 0);
      c = ($urandom_range(40) == 0);
      w = ($urandom_range(12) == 0);
      if ($urandom_range(500) == 0) do_reset();
      cycle(e, c, w, int'($urandom_range(7)), int'($urandom_range(6)),
            int'($urandom_range(3)), lvl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
